rf_writeback_unit: RTL and testbench
====================================

// Module: rf_writeback_unit
// PURPOSE
//  Producer side of the register-file write port (rr_we/rr_rd/rr_datard). Merges two result sources:
//  - the single-cycle ALU path, which has priority;
//  - the long-latency path (LSU / mul-div), which uses a valid/ready handshake and a DEPTH-entry FIFO.
//  Keeps a 32-bit pending scoreboard of long-latency destinations and raises a read-hazard stall for the decoder.
// PARAMETERS
//  XLEN   32  data width of a register
//  DEPTH  4   long-latency result FIFO entries; power of two, >=2
// PORTS
//  clk_i          in   1     clock, rising edge
//  rst_i          in   1     reset, asynchronous, active-high
//  alu_valid_i    in   1     ALU result present this cycle (no backpressure)
//  alu_rd_i       in   5     ALU destination
//  alu_data_i     in   XLEN  ALU result
//  ll_valid_i     in   1     long-latency result offered
//  ll_ready_o     out  1     FIFO can accept (= !full)
//  ll_rd_i        in   5     long-latency destination
//  ll_data_i      in   XLEN  long-latency result
//  iss_valid_i    in   1     long-latency op issued this cycle
//  iss_rd_i       in   5     its destination
//  iss_ready_o    out  1     issue allowed (= !pending[iss_rd_i] || iss_rd_i==0)
//  hz_rs1_i       in   5     decoder source 1
//  hz_rs2_i       in   5     decoder source 2
//  hz_stall_o     out  1     pending[rs1] | pending[rs2]; combinational
//  rr_we_o        out  1     register-file write enable
//  rr_rd_o        out  5     register-file destination
//  rr_datard_o    out  XLEN  register-file write data
// BEHAVIOUR
//  Reset (async, on rst_i high, whole block):
//  - FIFO count, read pointer and write pointer = 0; pending = 0.
//  - Outputs: ll_ready_o=1, rr_we_o=0, rr_rd_o=0, rr_datard_o=0, hz_stall_o=0.
//  - Reset mid-operation discards all queued results and clears all pending bits.
//  FIFO:
//  - Push on ll_valid_i & ll_ready_o. Pop when the write mux selects the FIFO head.
//  - Pointers wrap modulo DEPTH.
//  - ll_ready_o comes from the registered count only. When full, it stays 0 even if a pop occurs in the same cycle.
//  - Push and pop in the same cycle with count>0: count unchanged.
//  Write mux (combinational, same cycle):
//  - If alu_valid_i: write the ALU result. The FIFO holds.
//  - Else if count>0: write the FIFO head and pop.
//  - Else: no write.
//  - A long-latency result is never bypassed. Minimum latency from accept to rr_we_o is 1 cycle.
//  - Results leave the FIFO in order of acceptance.
//  x0 rule:
//  - A selected write with rd==0 drives rr_we_o=0, but a FIFO entry is still popped.
//  - Whenever rr_we_o=0, rr_rd_o and rr_datard_o are 0.
//  Scoreboard:
//  - Issue with iss_valid_i & iss_ready_o & iss_rd_i!=0 sets pending[iss_rd_i] at the clock edge.
//  - A FIFO-sourced write with rd!=0 clears pending[rd] at the same edge as the register-file write.
//  - If the same rd is set and cleared in one cycle, set wins.
//  - ALU writes never touch pending.
//  - Reads of x0 never stall.
//  Widths: rd fields 5 bits; data passed unmodified, no extension.
// TESTING
//  1 ALU only: alu_valid=1, rd=5, data=0xDEADBEEF -> same cycle rr_we=1, rr_rd=5, rr_datard=0xDEADBEEF.
//  2 Collision: issue x7; push x7=0x1234 while ALU is valid 3 cycles
//    -> x7 is written in the first cycle with ALU idle; pending[7]=0 after that edge.
//  3 Full: hold ALU valid, push 5 results x1..x5 -> ll_ready=0 after 4 accepts; 5th held.
//    After ALU drops: writes x1,x2,x3,x4,x5 on consecutive cycles; no loss, no duplicates.
//  4 x0: ALU rd=0 -> rr_we=0. FIFO entry rd=0 -> popped, rr_we=0. Issue rd=0 -> pending unchanged.
//  5 Hazard: issue x9, hz_rs1=9 -> hz_stall=1 until the x9 commit edge.
//    Second issue to x9 while pending -> iss_ready=0.
//  6 Reset with 2 queued and pending[3,4]=1 -> count=0, pending=0, ll_ready=1, rr_we=0; no stale write after release.

Source files
------------

// File: rtl/rf_writeback_unit.sv
// Register-file write-back merger: priority ALU path plus a queued long-latency path,
// with a pending-destination scoreboard that drives the decoder read-hazard stall.
module rf_writeback_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            alu_valid_i,
  input  logic [4:0]      alu_rd_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic            ll_valid_i,
  output logic            ll_ready_o,
  input  logic [4:0]      ll_rd_i,
  input  logic [XLEN-1:0] ll_data_i,
  input  logic            iss_valid_i,
  input  logic [4:0]      iss_rd_i,
  output logic            iss_ready_o,
  input  logic [4:0]      hz_rs1_i,
  input  logic [4:0]      hz_rs2_i,
  output logic            hz_stall_o,
  output logic            rr_we_o,
  output logic [4:0]      rr_rd_o,
  output logic [XLEN-1:0] rr_datard_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  fifo_data [DEPTH];
  logic [4:0]       fifo_rd   [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      pending;
  logic [31:0]      pending_nxt;

  logic             push;
  logic             pop;
  logic             fifo_nonempty;
  logic             sel_valid;
  logic [4:0]       sel_rd;
  logic [XLEN-1:0]  sel_data;
  logic             iss_fire;

  // Ready depends only on the registered count, so a same-cycle pop cannot open a full FIFO.
  assign ll_ready_o    = (count != CNT_W'(DEPTH));
  assign fifo_nonempty = (count != '0);
  assign push          = ll_valid_i & ll_ready_o;
  assign pop           = ~alu_valid_i & fifo_nonempty;

  assign iss_ready_o = ~pending[iss_rd_i] | (iss_rd_i == 5'd0);
  assign iss_fire    = iss_valid_i & iss_ready_o & (iss_rd_i != 5'd0);

  assign hz_stall_o = ((hz_rs1_i != 5'd0) & pending[hz_rs1_i]) |
                      ((hz_rs2_i != 5'd0) & pending[hz_rs2_i]);

  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (alu_valid_i) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd_i;
      sel_data  = alu_data_i;
    end else if (fifo_nonempty) begin
      sel_valid = 1'b1;
      sel_rd    = fifo_rd[rd_ptr];
      sel_data  = fifo_data[rd_ptr];
    end
  end

  always_comb begin
    rr_we_o     = sel_valid & (sel_rd != 5'd0);
    rr_rd_o     = '0;
    rr_datard_o = '0;
    if (rr_we_o) begin
      rr_rd_o     = sel_rd;
      rr_datard_o = sel_data;
    end
  end

  // Clear from the committing FIFO entry first, then apply the issue so a set wins a same-rd clash.
  always_comb begin
    pending_nxt = pending;
    if (pop && (fifo_rd[rd_ptr] != 5'd0)) begin
      pending_nxt[fifo_rd[rd_ptr]] = 1'b0;
    end
    if (iss_fire) begin
      pending_nxt[iss_rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_ptr] <= ll_data_i;
      fifo_rd[wr_ptr]   <= ll_rd_i;
    end
  end

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Directed self-checking bench for rf_writeback_unit: ALU priority, FIFO ordering/full,
// x0 handling, scoreboard hazards and mid-operation reset.
module tb_rf_writeback_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        ll_valid_i;
  logic        ll_ready_o;
  logic [4:0]  ll_rd_i;
  logic [31:0] ll_data_i;
  logic        iss_valid_i;
  logic [4:0]  iss_rd_i;
  logic        iss_ready_o;
  logic [4:0]  hz_rs1_i;
  logic [4:0]  hz_rs2_i;
  logic        hz_stall_o;
  logic        rr_we_o;
  logic [4:0]  rr_rd_o;
  logic [31:0] rr_datard_o;

  int checks   = 0;
  int failures = 0;

  rf_writeback_unit #(.XLEN(32), .DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .ll_valid_i(ll_valid_i), .ll_ready_o(ll_ready_o), .ll_rd_i(ll_rd_i), .ll_data_i(ll_data_i),
    .iss_valid_i(iss_valid_i), .iss_rd_i(iss_rd_i), .iss_ready_o(iss_ready_o),
    .hz_rs1_i(hz_rs1_i), .hz_rs2_i(hz_rs2_i), .hz_stall_o(hz_stall_o),
    .rr_we_o(rr_we_o), .rr_rd_o(rr_rd_o), .rr_datard_o(rr_datard_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change on the falling edge; outputs are sampled 1ns later, well away from the rising edge.
  task automatic idle_inputs();
    alu_valid_i = 1'b0; alu_rd_i = '0; alu_data_i = '0;
    ll_valid_i  = 1'b0; ll_rd_i  = '0; ll_data_i  = '0;
    iss_valid_i = 1'b0; iss_rd_i = '0;
    hz_rs1_i    = '0;   hz_rs2_i = '0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk_i);
    #1;
    checks++; if (ll_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ll_ready got=%0b exp=1", ll_ready_o); end
    checks++; if (rr_we_o !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", rr_we_o); end
    checks++; if (rr_rd_o !== 5'd0 || rr_datard_o !== 32'd0) begin failures++; $display("FAIL reset_rd_data got=%0d/%h exp=0/0", rr_rd_o, rr_datard_o); end
    checks++; if (hz_stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", hz_stall_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_alu_only();
    @(negedge clk_i);
    alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hDEADBEEF;
    #1;
    checks++; if (rr_we_o !== 1'b1 || rr_rd_o !== 5'd5 || rr_datard_o !== 32'hDEADBEEF) begin
      failures++; $display("FAIL alu_only got=%0b/%0d/%h exp=1/5/deadbeef", rr_we_o, rr_rd_o, rr_datard_o); end
    @(negedge clk_i);
    idle_inputs();
  endtask

  task automatic test_collision();
    @(negedge clk_i);
    iss_valid_i = 1'b1; iss_rd_i = 5'd7;
    #1;
    checks++; if (iss_ready_o !== 1'b1) begin failures++; $display("FAIL coll_iss_ready got=%0b exp=1", iss_ready_o); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      iss_valid_i = 1'b0; hz_rs1_i = 5'd7;
      alu_valid_i = 1'b1; alu_rd_i = 5'd2; alu_data_i = 32'hA0 + 32'(c);
      ll_valid_i  = (c == 0); ll_rd_i = 5'd7; ll_data_i = 32'h1234;
      #1;
      checks++; if (rr_we_o !== 1'b1 || rr_rd_o !== 5'd2 || rr_datard_o !== 32'hA0 + 32'(c)) begin
        failures++; $display("FAIL coll_alu_prio cyc=%0d got=%0b/%0d/%h exp=1/2/%h", c, rr_we_o, rr_rd_o, rr_datard_o, 32'hA0 + 32'(c)); end
      checks++; if (hz_stall_o !== 1'b1) begin failures++; $display("FAIL coll_stall_held cyc=%0d got=%0b exp=1", c, hz_stall_o); end
    end
    @(negedge clk_i);
    idle_inputs(); hz_rs1_i = 5'd7;
    #1;
    checks++; if (rr_we_o !== 1'b1 || rr_rd_o !== 5'd7 || rr_datard_o !== 32'h1234) begin
      failures++; $display("FAIL coll_ll_write got=%0b/%0d/%h exp=1/7/1234", rr_we_o, rr_rd_o, rr_datard_o); end
    checks++; if (hz_stall_o !== 1'b1) begin failures++; $display("FAIL coll_stall_before_edge got=%0b exp=1", hz_stall_o); end
    @(negedge clk_i);
    #1;
    checks++; if (hz_stall_o !== 1'b0) begin failures++; $display("FAIL coll_pending_cleared got=%0b exp=0", hz_stall_o); end
    checks++; if (rr_we_o !== 1'b0) begin failures++; $display("FAIL coll_no_dup got=%0b exp=0", rr_we_o); end
    idle_inputs();
  endtask

  task automatic test_full();
    logic exp_ready;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk_i);
      alu_valid_i = 1'b1; alu_rd_i = 5'd6; alu_data_i = 32'h66;
      ll_valid_i = 1'b1; ll_rd_i = 5'(i); ll_data_i = 32'h100 + 32'(i);
      exp_ready = (i <= 4);
      #1;
      checks++; if (ll_ready_o !== exp_ready) begin failures++; $display("FAIL full_ready i=%0d got=%0b exp=%0b", i, ll_ready_o, exp_ready); end
    end
    // ALU drops while x5 is still offered: count is 4 so ready stays low despite the pop.
    @(negedge clk_i);
    alu_valid_i = 1'b0;
    #1;
    checks++; if (ll_ready_o !== 1'b0) begin failures++; $display("FAIL full_ready_pop got=%0b exp=0", ll_ready_o); end
    checks++; if (rr_we_o !== 1'b1 || rr_rd_o !== 5'd1 || rr_datard_o !== 32'h101) begin
      failures++; $display("FAIL full_drain k=1 got=%0b/%0d/%h exp=1/1/101", rr_we_o, rr_rd_o, rr_datard_o); end
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk_i);
      if (k == 3) ll_valid_i = 1'b0;
      #1;
      if (k == 2) begin
        checks++; if (ll_ready_o !== 1'b1) begin failures++; $display("FAIL full_ready_reopen got=%0b exp=1", ll_ready_o); end
      end
      checks++; if (rr_we_o !== 1'b1 || rr_rd_o !== 5'(k) || rr_datard_o !== 32'h100 + 32'(k)) begin
        failures++; $display("FAIL full_drain k=%0d got=%0b/%0d/%h exp=1/%0d/%h", k, rr_we_o, rr_rd_o, rr_datard_o, k, 32'h100 + 32'(k)); end
    end
    @(negedge clk_i);
    #1;
    checks++; if (rr_we_o !== 1'b0 || ll_ready_o !== 1'b1) begin
      failures++; $display("FAIL full_empty got=we%0b/rdy%0b exp=we0/rdy1", rr_we_o, ll_ready_o); end
    idle_inputs();
  endtask

  task automatic test_x0();
    @(negedge clk_i);
    alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'h55;
    #1;
    checks++; if (rr_we_o !== 1'b0 || rr_rd_o !== 5'd0 || rr_datard_o !== 32'd0) begin
      failures++; $display("FAIL x0_alu got=%0b/%0d/%h exp=0/0/0", rr_we_o, rr_rd_o, rr_datard_o); end
    @(negedge clk_i);
    idle_inputs(); ll_valid_i = 1'b1; ll_rd_i = 5'd0; ll_data_i = 32'h77;
    @(negedge clk_i);
    ll_rd_i = 5'd3; ll_data_i = 32'h33;
    #1;
    checks++; if (rr_we_o !== 1'b0 || rr_datard_o !== 32'd0) begin
      failures++; $display("FAIL x0_fifo got=%0b/%h exp=0/0", rr_we_o, rr_datard_o); end
    @(negedge clk_i);
    ll_valid_i = 1'b0;
    #1;
    checks++; if (rr_we_o !== 1'b1 || rr_rd_o !== 5'd3 || rr_datard_o !== 32'h33) begin
      failures++; $display("FAIL x0_popped got=%0b/%0d/%h exp=1/3/33", rr_we_o, rr_rd_o, rr_datard_o); end
    @(negedge clk_i);
    iss_valid_i = 1'b1; iss_rd_i = 5'd0;
    #1;
    checks++; if (rr_we_o !== 1'b0 || iss_ready_o !== 1'b1) begin
      failures++; $display("FAIL x0_issue_ready got=we%0b/rdy%0b exp=we0/rdy1", rr_we_o, iss_ready_o); end
    @(negedge clk_i);
    #1;
    checks++; if (iss_ready_o !== 1'b1 || hz_stall_o !== 1'b0) begin
      failures++; $display("FAIL x0_no_pending got=rdy%0b/stall%0b exp=rdy1/stall0", iss_ready_o, hz_stall_o); end
    idle_inputs();
  endtask

  task automatic test_hazard();
    @(negedge clk_i);
    iss_valid_i = 1'b1; iss_rd_i = 5'd9;
    @(negedge clk_i);
    hz_rs2_i = 5'd9;
    #1;
    checks++; if (iss_ready_o !== 1'b0) begin failures++; $display("FAIL hz_reissue_block got=%0b exp=0", iss_ready_o); end
    checks++; if (hz_stall_o !== 1'b1) begin failures++; $display("FAIL hz_stall_rs2 got=%0b exp=1", hz_stall_o); end
    @(negedge clk_i);
    iss_valid_i = 1'b0; hz_rs2_i = 5'd0; hz_rs1_i = 5'd9;
    ll_valid_i = 1'b1; ll_rd_i = 5'd9; ll_data_i = 32'h99;
    #1;
    checks++; if (hz_stall_o !== 1'b1) begin failures++; $display("FAIL hz_stall_rs1 got=%0b exp=1", hz_stall_o); end
    @(negedge clk_i);
    ll_valid_i = 1'b0;
    #1;
    checks++; if (rr_we_o !== 1'b1 || rr_rd_o !== 5'd9 || hz_stall_o !== 1'b1) begin
      failures++; $display("FAIL hz_commit got=we%0b/rd%0d/stall%0b exp=we1/rd9/stall1", rr_we_o, rr_rd_o, hz_stall_o); end
    @(negedge clk_i);
    iss_rd_i = 5'd9;
    #1;
    checks++; if (hz_stall_o !== 1'b0 || iss_ready_o !== 1'b1) begin
      failures++; $display("FAIL hz_released got=stall%0b/rdy%0b exp=stall0/rdy1", hz_stall_o, iss_ready_o); end
    // x11 is committed from the FIFO in the same cycle it is issued: the set must survive.
    idle_inputs();
    ll_valid_i = 1'b1; ll_rd_i = 5'd11; ll_data_i = 32'hB;
    @(negedge clk_i);
    ll_valid_i = 1'b0; iss_valid_i = 1'b1; iss_rd_i = 5'd11;
    #1;
    checks++; if (rr_we_o !== 1'b1 || rr_rd_o !== 5'd11 || iss_ready_o !== 1'b1) begin
      failures++; $display("FAIL hz_clash_setup got=we%0b/rd%0d/rdy%0b exp=we1/rd11/rdy1", rr_we_o, rr_rd_o, iss_ready_o); end
    @(negedge clk_i);
    iss_valid_i = 1'b0; hz_rs1_i = 5'd11;
    #1;
    checks++; if (hz_stall_o !== 1'b1) begin failures++; $display("FAIL hz_set_wins got=%0b exp=1", hz_stall_o); end
    // Drain x11 so later tests start clean.
    ll_valid_i = 1'b1; ll_rd_i = 5'd11; ll_data_i = 32'hC;
    @(negedge clk_i);
    ll_valid_i = 1'b0;
    @(negedge clk_i);
    #1;
    checks++; if (hz_stall_o !== 1'b0) begin failures++; $display("FAIL hz_x11_cleared got=%0b exp=0", hz_stall_o); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i);
    iss_valid_i = 1'b1; iss_rd_i = 5'd3;
    @(negedge clk_i);
    iss_rd_i = 5'd4;
    alu_valid_i = 1'b1; alu_rd_i = 5'd8; alu_data_i = 32'h8;
    ll_valid_i = 1'b1; ll_rd_i = 5'd3; ll_data_i = 32'h3;
    @(negedge clk_i);
    iss_valid_i = 1'b0; ll_rd_i = 5'd4; ll_data_i = 32'h4;
    hz_rs1_i = 5'd3; hz_rs2_i = 5'd4;
    @(negedge clk_i);
    ll_valid_i = 1'b0; hz_rs2_i = 5'd0;
    #1;
    checks++; if (hz_stall_o !== 1'b1) begin failures++; $display("FAIL rst_pre_pending got=%0b exp=1", hz_stall_o); end
    alu_valid_i = 1'b0; hz_rs2_i = 5'd4;
    rst_i = 1'b1;
    #1;
    checks++; if (ll_ready_o !== 1'b1 || rr_we_o !== 1'b0 || hz_stall_o !== 1'b0) begin
      failures++; $display("FAIL rst_mid got=rdy%0b/we%0b/stall%0b exp=rdy1/we0/stall0", ll_ready_o, rr_we_o, hz_stall_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (rr_we_o !== 1'b0 || rr_rd_o !== 5'd0 || hz_stall_o !== 1'b0) begin
        failures++; $display("FAIL rst_no_stale cyc=%0d got=we%0b/rd%0d/stall%0b exp=we0/rd0/stall0", c, rr_we_o, rr_rd_o, hz_stall_o); end
      @(negedge clk_i);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_collision();
    test_full();
    test_x0();
    test_hazard();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
